// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
// Holds default parameter values and the pointer-width helper.
package arb_pkg;

  localparam int NumInDefault  = 4;
  localparam bit LockInDefault = 1'b1;

  // Pointer width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_lsb_select.sv
// Isolates the lowest set bit of a vector (in & -in).
// Produces all-zero when the input is all-zero.
module onehot_lsb_select #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  assign out_o = in_i & (-in_i);

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with one-hot grant and optional decision lock.
// Arbitration is combinational from the registered fairness pointer and lock.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int NumIn    = NumInDefault,
  parameter bit LockIn   = LockInDefault,
  parameter int IdxWidth = idx_width(NumIn)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumIn-1:0] req_i,
  output logic [NumIn-1:0] gnt_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [NumIn-1:0] gnt_oh_o
);

  // valid_o/ready_i: a transfer happens in every cycle where both are high.
  // valid_o and gnt_oh_o never depend on ready_i; with LockIn a stalled
  // winner keeps being presented until it is taken or drops its request.

  logic [IdxWidth-1:0] rr_q;
  logic                lock_q;
  logic [NumIn-1:0]    lock_oh_q;

  logic [NumIn-1:0]    mask;
  logic [NumIn-1:0]    masked;
  logic [NumIn-1:0]    masked_lsb;
  logic [NumIn-1:0]    req_lsb;
  logic [NumIn-1:0]    arb_oh;
  logic [IdxWidth-1:0] win_idx;
  logic [IdxWidth-1:0] rr_next;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NumIn; i++) begin
      mask[i] = (i >= int'(rr_q));
    end
  end

  assign masked = req_i & mask;

  onehot_lsb_select #(.Width(NumIn)) u_sel_masked (
    .in_i  (masked),
    .out_o (masked_lsb)
  );

  onehot_lsb_select #(.Width(NumIn)) u_sel_req (
    .in_i  (req_i),
    .out_o (req_lsb)
  );

  // Wrap to the unmasked search when nothing at or above the pointer requests.
  assign arb_oh   = (masked != '0) ? masked_lsb : req_lsb;
  assign gnt_oh_o = lock_q ? (req_i & lock_oh_q) : arb_oh;
  assign valid_o  = lock_q ? |(req_i & lock_oh_q) : |req_i;
  assign gnt_o    = gnt_oh_o & {NumIn{ready_i}};

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (gnt_oh_o[i]) win_idx = IdxWidth'(i);
    end
  end

  assign rr_next = (win_idx == IdxWidth'(NumIn - 1)) ? '0 : win_idx + IdxWidth'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_oh_q <= '0;
    end else if (valid_o && ready_i) begin
      rr_q   <= rr_next;
      lock_q <= 1'b0;
    end else if (valid_o) begin
      if (LockIn) begin
        lock_q    <= 1'b1;
        lock_oh_q <= gnt_oh_o;
      end
    end else begin
      lock_q <= 1'b0;
    end
  end

  a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> |(req_i & lock_oh_q))
    else $error("locked requester dropped its request before grant");

  a_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_oh_o))
    else $error("gnt_oh_o is not one-hot or zero");

  a_subset: assert property (@(posedge clk_i) disable iff (rst_i)
    !lock_q |-> ((gnt_oh_o & ~req_i) == '0))
    else $error("gnt_oh_o grants a non-requester");

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: a locking and a non-locking instance checked
// every cycle against a circular-search model, plus directed literal vectors.
module tb_rr_onehot_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_a = '0, req_b = '0;
  logic         rdy_a = 1'b0, rdy_b = 1'b0;
  logic [N-1:0] gnt_a, gnt_b, oh_a, oh_b;
  logic         valid_a, valid_b;
  logic         chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int m_ptr[2]    = '{0, 0};
  bit m_locked[2] = '{0, 0};
  int m_lk[2]     = '{0, 0};

  // clock/reset block
  always #5 clk = ~clk;

  rr_onehot_arbiter #(.NumIn(N), .LockIn(1'b1)) u_dut_lock (
    .clk_i (clk), .rst_i (rst), .req_i (req_a), .gnt_o (gnt_a),
    .valid_o (valid_a), .ready_i (rdy_a), .gnt_oh_o (oh_a)
  );

  rr_onehot_arbiter #(.NumIn(N), .LockIn(1'b0)) u_dut_nolock (
    .clk_i (clk), .rst_i (rst), .req_i (req_b), .gnt_o (gnt_b),
    .valid_o (valid_b), .ready_i (rdy_b), .gnt_oh_o (oh_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: first requester found searching circularly from the pointer,
  // or the held winner while a lock is active.
  task automatic model_cycle(input int u, input logic [N-1:0] req, input logic rdy,
                             input logic rst_now, input logic v_act,
                             input logic [N-1:0] oh_act, input logic [N-1:0] g_act);
    int win;
    int j;
    logic [N-1:0] exp_oh;
    string pfx;
    pfx = (u == 0) ? "lock" : "nolock";
    win = -1;
    if (m_locked[u]) begin
      if (req[m_lk[u]]) win = m_lk[u];
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr[u] + k) % N;
        if (win < 0 && req[j]) win = j;
      end
    end
    exp_oh = '0;
    if (win >= 0) exp_oh[win] = 1'b1;
    check({pfx, "_valid"}, 32'(v_act), 32'(win >= 0));
    check({pfx, "_gnt_oh"}, 32'(oh_act), 32'(exp_oh));
    check({pfx, "_gnt"}, 32'(g_act), 32'(rdy ? exp_oh : '0));
    if (rst_now) begin
      m_ptr[u] = 0;
      m_locked[u] = 0;
    end else if (win >= 0 && rdy) begin
      m_ptr[u] = (win + 1) % N;
      m_locked[u] = 0;
    end else if (win >= 0) begin
      if (u == 0) begin
        m_locked[u] = 1;
        m_lk[u] = win;
      end
    end else begin
      m_locked[u] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      model_cycle(0, req_a, rdy_a, rst, valid_a, oh_a, gnt_a);
      model_cycle(1, req_b, rdy_b, rst, valid_b, oh_b, gnt_b);
    end
  end

  // driver tasks: inputs change just after the rising edge, sampled at the falling edge
  task automatic drive_a(input logic [N-1:0] r, input logic y);
    @(posedge clk); #1;
    rst = 1'b0; req_a = r; rdy_a = y;
    @(negedge clk);
  endtask

  task automatic drive_b(input logic [N-1:0] r, input logic y);
    @(posedge clk); #1;
    rst = 1'b0; req_b = r; rdy_b = y;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_a = '0; rdy_a = 1'b0; req_b = '0; rdy_b = 1'b0;
  endtask

  logic [N-1:0] seq2[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] seq3[3] = '{4'b0010, 4'b1000, 4'b0010};

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) begin
      drive_a(4'b0000, 1'b0);
      check("idle_valid", 32'(valid_a), 32'd0);
      check("idle_gnt_oh", 32'(oh_a), 32'd0);
      check("idle_gnt", 32'(gnt_a), 32'd0);
    end

    // 2: full rotation with pointer wrap
    for (int c = 0; c < 5; c++) begin
      drive_a(4'b1111, 1'b1);
      check("rot_gnt_oh", 32'(oh_a), 32'(seq2[c]));
      check("rot_gnt", 32'(gnt_a), 32'(seq2[c]));
    end

    // 3: idle requesters skipped
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive_a(4'b1010, 1'b1);
      check("skip_gnt_oh", 32'(oh_a), 32'(seq3[c]));
    end

    // 4: lock holds across a stall even when new requests appear
    do_reset();
    drive_a(4'b0011, 1'b0);
    check("lk1_gnt_oh", 32'(oh_a), 32'h1);
    check("lk1_gnt", 32'(gnt_a), 32'h0);
    drive_a(4'b0111, 1'b0);
    check("lk2_gnt_oh", 32'(oh_a), 32'h1);
    drive_a(4'b0111, 1'b1);
    check("lk3_gnt", 32'(gnt_a), 32'h1);
    drive_a(4'b0111, 1'b1);
    check("lk4_gnt_oh", 32'(oh_a), 32'h2);

    // 5: no lock, winner follows requests, pointer stays put
    do_reset();
    drive_a(4'b0000, 1'b0);
    drive_b(4'b0010, 1'b0);
    check("nl1_gnt_oh", 32'(oh_b), 32'h2);
    drive_b(4'b0001, 1'b0);
    check("nl2_gnt_oh", 32'(oh_b), 32'h1);
    drive_b(4'b1111, 1'b1);
    check("nl3_gnt_oh", 32'(oh_b), 32'h1);
    drive_b(4'b1111, 1'b1);
    check("nl4_gnt_oh", 32'(oh_b), 32'h2);
    drive_b(4'b0000, 1'b0);

    // 6: reset while locked clears the lock and the pointer
    do_reset();
    drive_a(4'b1111, 1'b1);
    drive_a(4'b1000, 1'b0);
    check("rl1_gnt_oh", 32'(oh_a), 32'h8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rl2_gnt_oh", 32'(oh_a), 32'h8);
    drive_a(4'b1100, 1'b1);
    check("rl3_gnt_oh", 32'(oh_a), 32'h4);
    drive_a(4'b1100, 1'b1);
    check("rl4_gnt_oh", 32'(oh_a), 32'h8);

    drive_a(4'b0000, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
